// File: rtl/cpu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_clock_ctrl
//
// Generates a single-cycle clock-enable strobe (cpu_ce) for the Z80 core from
// the system clock, so the core runs in the clk domain instead of from a
// derived clock. Four modes are loaded through cfg_load: stop, continuous run
// at a programmable divide rate, single-step from an external button level,
// and an N-strobe burst.
//
// Parameters:
//   DIV_W    width of the divisor (strobe period is div+1 clk cycles)
//   BURST_W  width of the burst length
//   CNT_W    width of the issued-strobe counter
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   mode       00 stop, 01 run, 10 step, 11 burst (taken on cfg_load)
//   div        divisor (taken on cfg_load)
//   burst_len  strobes per burst (taken on cfg_load)
//   cfg_load   one-cycle pulse: latch configuration and (re)start the mode
//   step_req   asynchronous level; each rising edge requests one step strobe
//   hold       WAIT-style pause: freezes counting and suppresses strobes
//   cpu_ce     registered one-cycle clock-enable strobe
//   busy       registered, high while the controller is not idle
//   done       registered one-cycle pulse when a burst completes
//   ce_count   registered count of issued strobes, wraps naturally
// ---------------------------------------------------------------------------
module cpu_clock_ctrl #(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cfg_load,
  input  logic               step_req,
  input  logic               hold,
  output logic               cpu_ce,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ce_count
);

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_ARM,
    BURST
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [BURST_W-1:0] burst_rem;
  logic               step_s1;
  logic               step_s2;
  logic               step_s3;
  logic               step_pend;
  logic               step_edge;
  logic               term_cnt;

  // step_s3 is the previous synchronized value; a 0->1 step between s3 and
  // s2 is one button press.
  assign step_edge = step_s2 & ~step_s3;
  assign term_cnt  = (div_cnt == div_q);

  // Two-flop synchronizer for the asynchronous step_req level, plus the
  // edge-detect flop. It runs in every state so an old level never looks
  // like a fresh edge when step mode is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      step_s1 <= step_req;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  // Control FSM. cfg_load has absolute priority: it restarts the selected
  // mode even during hold and swallows any strobe due in the same cycle.
  // busy is the registered "not idle" flag, so it trails the state by one
  // cycle and stays high through the final burst strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_q     <= '0;
      div_cnt   <= '0;
      burst_rem <= '0;
      step_pend <= 1'b0;
      cpu_ce    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy   <= (state != IDLE);
      cpu_ce <= 1'b0;
      done   <= 1'b0;
      if (cfg_load) begin
        div_q     <= div;
        div_cnt   <= '0;
        burst_rem <= burst_len;
        step_pend <= 1'b0;
        case (mode)
          MODE_STOP: state <= IDLE;
          MODE_RUN:  state <= RUN;
          MODE_STEP: state <= STEP_ARM;
          MODE_BURST: begin
            // An empty burst completes immediately without a strobe.
            if (burst_len != '0) begin
              state <= BURST;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
          end
          RUN: begin
            if (!hold) begin
              if (term_cnt) begin
                cpu_ce  <= 1'b1;
                div_cnt <= '0;
              end else begin
                div_cnt <= div_cnt + DIV_W'(1);
              end
            end
          end
          BURST: begin
            if (!hold) begin
              if (term_cnt) begin
                cpu_ce    <= 1'b1;
                div_cnt   <= '0;
                burst_rem <= burst_rem - BURST_W'(1);
                if (burst_rem == BURST_W'(1)) begin
                  done  <= 1'b1;
                  state <= IDLE;
                end
              end else begin
                div_cnt <= div_cnt + DIV_W'(1);
              end
            end
          end
          STEP_ARM: begin
            // One request can wait out a hold; edges arriving while it
            // waits are dropped rather than queued.
            if (step_pend && !hold) begin
              cpu_ce    <= 1'b1;
              step_pend <= 1'b0;
            end else if (step_edge) begin
              step_pend <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Strobe counter: counts each cycle in which cpu_ce was high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_count <= '0;
    end else if (cpu_ce) begin
      ce_count <= ce_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_clock_ctrl
//
// Self-checking bench for cpu_clock_ctrl. A behavioural model counts active
// (non-hold) cycles since each load and tracks step_req as sampled at each
// clock edge; every cycle all outputs are compared with it. Directed
// sequences add fixed-latency and fixed-count checks, followed by a random
// phase. The strobe counter is instantiated narrow so its wrap from all-ones
// to zero is reached in a few thousand cycles.
// ---------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  localparam int DIV_W    = 16;
  localparam int BURST_W  = 8;
  localparam int TB_CNT_W = 12;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [1:0]          mode;
  logic [DIV_W-1:0]    div;
  logic [BURST_W-1:0]  burst_len;
  logic                cfg_load;
  logic                step_req;
  logic                hold;
  logic                cpu_ce;
  logic                busy;
  logic                done;
  logic [TB_CNT_W-1:0] ce_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: 0 idle, 1 run, 2 step, 3 burst.
  int m_mode;
  int m_div;
  int m_blen;
  int m_active;
  int m_issued;
  bit m_pending;
  bit m_rise;
  bit m_new_ce;
  bit m_new_done;
  bit h1, h2, h3;
  bit e_ce, e_busy, e_done;
  int e_count;

  // Directed-sequence bookkeeping.
  int seen, lat, first_ce, last_ce, done_at, busy_low, ticks, act;

  // 100 MHz-style clock, active edge at odd multiples of 5.
  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .DIV_W  (DIV_W),
    .BURST_W(BURST_W),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .div      (div),
    .burst_len(burst_len),
    .cfg_load (cfg_load),
    .step_req (step_req),
    .hold     (hold),
    .cpu_ce   (cpu_ce),
    .busy     (busy),
    .done     (done),
    .ce_count (ce_count)
  );

  // Reference model: strobes fall on every (div+1)-th active cycle after a
  // load; a step request is the 0->1 change of step_req between the samples
  // taken two and three edges ago, then waits out any hold.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_div = 0; m_blen = 0; m_active = 0; m_issued = 0;
      m_pending = 0; h1 = 0; h2 = 0; h3 = 0;
      e_ce = 0; e_busy = 0; e_done = 0; e_count = 0;
    end else begin
      m_rise = h2 && !h3;
      if (e_ce) e_count = (e_count + 1) % (CNT_MAX + 1);
      e_busy = (m_mode != 0);
      m_new_ce = 0;
      m_new_done = 0;
      if (cfg_load) begin
        m_div = int'(div);
        m_blen = int'(burst_len);
        m_active = 0;
        m_issued = 0;
        m_pending = 0;
        case (mode)
          2'b00: m_mode = 0;
          2'b01: m_mode = 1;
          2'b10: m_mode = 2;
          default: begin
            if (m_blen == 0) begin
              m_mode = 0;
              m_new_done = 1;
            end else begin
              m_mode = 3;
            end
          end
        endcase
      end else if ((m_mode == 1 || m_mode == 3) && !hold) begin
        m_active++;
        if (m_active % (m_div + 1) == 0) begin
          m_new_ce = 1;
          if (m_mode == 3) begin
            m_issued++;
            if (m_issued == m_blen) begin
              m_new_done = 1;
              m_mode = 0;
            end
          end
        end
      end else if (m_mode == 2) begin
        if (m_pending && !hold) begin
          m_new_ce = 1;
          m_pending = 0;
        end else if (m_rise) begin
          m_pending = 1;
        end
      end
      h3 = h2;
      h2 = h1;
      h1 = step_req;
      e_ce = m_new_ce;
      e_done = m_new_done;
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives the configuration inputs; called at a falling edge.
  task automatic applyStimulus(input logic ld, input logic [1:0] m,
                               input logic [DIV_W-1:0] d, input logic [BURST_W-1:0] b);
    cfg_load  = ld;
    mode      = m;
    div       = d;
    burst_len = b;
  endtask

  // Advances to the next falling edge and compares all outputs with the model.
  task automatic tick();
    @(negedge clk);
    checkOutput("cpu_ce", int'(cpu_ce), int'(e_ce));
    checkOutput("busy", int'(busy), int'(e_busy));
    checkOutput("done", int'(done), int'(e_done));
    checkOutput("ce_count", int'(ce_count), e_count);
  endtask

  // One-cycle cfg_load pulse; returns in the cycle right after the load edge.
  task automatic load_cfg(input logic [1:0] m, input int d, input int b);
    applyStimulus(1'b1, m, DIV_W'(d), BURST_W'(b));
    tick();
    cfg_load = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences followed by a random phase.
  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'b00, '0, '0);
    step_req = 1'b0;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ce", int'(cpu_ce), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_count", int'(ce_count), 0);
    reset_n = 1'b1;
    tick();
    tick();

    // RUN div=3: first strobe four cycles after load, then every four.
    load_cfg(2'b01, 3, 0);
    lat = -1; seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ce) begin
        if (lat < 0) lat = i;
        seen++;
      end
    end
    checkOutput("run_div3_first", lat, 4);
    checkOutput("run_div3_count", seen, 5);

    // Asynchronous reset mid-RUN, landing in a strobe cycle.
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_async_ce", int'(cpu_ce), 0);
    checkOutput("rst_async_busy", int'(busy), 0);
    checkOutput("rst_async_done", int'(done), 0);
    checkOutput("rst_async_count", int'(ce_count), 0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_ce) seen++;
    end
    checkOutput("rst_idle_strobes", seen, 0);
    checkOutput("rst_idle_busy", int'(busy), 0);

    // RUN div=0: a strobe every cycle; 100 strobes give ce_count 100.
    load_cfg(2'b01, 0, 0);
    seen = 0; ticks = 0;
    while (seen < 100 && ticks < 150) begin
      tick();
      ticks++;
      if (cpu_ce) seen++;
    end
    checkOutput("run_div0_ticks", ticks, 100);
    load_cfg(2'b00, 0, 0);
    tick();
    checkOutput("run_div0_count", int'(ce_count), 100);

    // RUN div=7 with hold raised while the counter sits at 5.
    load_cfg(2'b01, 7, 0);
    repeat (5) tick();
    hold = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ce) seen++;
    end
    checkOutput("hold_no_strobe", seen, 0);
    hold = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      tick();
      if (cpu_ce) lat = i;
    end
    checkOutput("hold_resume_lat", lat, 3);

    // BURST of 5 with div=1.
    load_cfg(2'b11, 1, 5);
    seen = 0; first_ce = -1; last_ce = -1; done_at = -1; busy_low = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_ce) begin
        seen++;
        if (first_ce < 0) first_ce = i;
        last_ce = i;
      end
      if (done) done_at = i;
      if (!busy && busy_low < 0) busy_low = i;
    end
    checkOutput("burst_count", seen, 5);
    checkOutput("burst_first", first_ce, 2);
    checkOutput("burst_last", last_ce, 10);
    checkOutput("burst_done_at", done_at, 10);
    checkOutput("burst_busy_low", busy_low, 11);

    // Empty burst: done right after the load, no strobe.
    load_cfg(2'b11, 1, 0);
    checkOutput("burst0_done", int'(done), 1);
    checkOutput("burst0_ce", int'(cpu_ce), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ce) seen++;
    end
    checkOutput("burst0_strobes", seen, 0);

    // STEP: three 5-cycle pulses, each strobing once at sample edge + 3.
    load_cfg(2'b10, 0, 0);
    tick();
    tick();
    seen = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
        if (i == 6) step_req = 1'b0;
        tick();
        if (cpu_ce) begin
          seen++;
          if (lat < 0) lat = i;
        end
      end
      checkOutput("step_latency", lat, 4);
    end
    checkOutput("step_count", seen, 3);

    // STEP pulse during hold: strobe on the first cycle with hold low.
    hold = 1'b1;
    step_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) step_req = 1'b0;
      tick();
      if (cpu_ce) seen++;
    end
    checkOutput("step_hold_none", seen, 0);
    hold = 1'b0;
    lat = -1;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      tick();
      if (cpu_ce) lat = i;
    end
    checkOutput("step_hold_release", lat, 1);

    // cfg_load on the terminal-count edge: no strobe, counter restarts.
    load_cfg(2'b01, 3, 0);
    repeat (7) tick();
    load_cfg(2'b01, 3, 0);
    checkOutput("load_tc_no_ce", int'(cpu_ce), 0);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      tick();
      if (cpu_ce) lat = i;
    end
    checkOutput("load_tc_restart", lat, 4);

    // cfg_load on the step-edge detection edge: the request is discarded.
    load_cfg(2'b10, 0, 0);
    repeat (4) tick();
    step_req = 1'b1;
    tick();
    tick();
    load_cfg(2'b10, 0, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) step_req = 1'b0;
      tick();
      if (cpu_ce) seen++;
    end
    checkOutput("load_step_discard", seen, 0);

    // Counter wrap: run to all-ones, then one more strobe gives zero.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    load_cfg(2'b01, 0, 0);
    seen = 0; ticks = 0;
    while (seen < CNT_MAX && ticks < CNT_MAX + 100) begin
      tick();
      ticks++;
      if (cpu_ce) seen++;
    end
    load_cfg(2'b00, 0, 0);
    tick();
    checkOutput("cnt_all_ones", int'(ce_count), CNT_MAX);
    load_cfg(2'b01, 0, 0);
    tick();
    tick();
    checkOutput("cnt_wrap_zero", int'(ce_count), 0);
    load_cfg(2'b00, 0, 0);

    // Random phase: random loads, holds and step_req toggles of >= 3 cycles.
    for (int r = 0; r < 400; r++) begin
      act = int'($urandom_range(0, 9));
      if (act < 2) begin
        load_cfg(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 6)));
      end else begin
        hold = ($urandom_range(0, 5) == 0);
        if (act >= 7) step_req = ~step_req;
        repeat ($urandom_range(3, 8)) tick();
      end
    end
    hold = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Clock-enable controller for the Z80 core. It generates a single-cycle `cpu_ce` strobe from the system clock in one of four software-selected modes: stop, continuous run at a programmable divide rate, single-step, or N-pulse burst. It sits between the debug/config register block and the CPU core, so the core can run from the single system clock domain instead of a derived clock.

## Interface
- `DIV_W`, 16: width of divisor; strobe period is `div+1` clk cycles.
- `BURST_W`, 8: width of burst length.
- `CNT_W`, 16: width of the issued-strobe counter.

- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode` in 2: 00 STOP, 01 RUN, 10 STEP, 11 BURST; sampled only on `cfg_load`.
- `div` in DIV_W: divisor; sampled only on `cfg_load`.
- `burst_len` in BURST_W: strobes per burst; sampled only on `cfg_load`.
- `cfg_load` in 1: one-cycle pulse that latches `mode`, `div` and `burst_len`, then (re)starts the mode.
- `step_req` in 1: asynchronous level, e.g. a button; each rising edge requests one strobe in STEP mode.
- `hold` in 1: freezes the divide counter and suppresses strobes (Z80 WAIT-style pause); no state is lost.
- `cpu_ce` out 1: registered one-cycle clock-enable strobe.
- `busy` out 1: registered; high when FSM ≠ IDLE.
- `done` out 1: registered one-cycle pulse at burst completion.
- `ce_count` out CNT_W: registered count of strobes issued, wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, RUN, STEP_ARM, BURST.
- `cfg_load` next state by `mode`:
  - STOP → IDLE.
  - RUN → RUN.
  - STEP → STEP_ARM.
  - BURST → BURST if `burst_len`≠0; else IDLE with `done` pulsed.
- On `cfg_load`: divide counter cleared to 0, burst remaining loaded with `burst_len`, pending step edge discarded.
- RUN:
  - Divide counter increments each non-hold cycle.
  - When counter == latched div: `cpu_ce`=1 and counter returns to 0.
  - div=0 gives `cpu_ce` every non-hold cycle.
- STEP_ARM:
  - `step_req` passes through a 2-flop synchronizer plus an edge-detect flop.
  - Each detected rising edge gives exactly one `cpu_ce`.
  - If `hold`=1 when the edge is detected, the strobe is deferred until `hold`=0.
  - At most one strobe is pending; further edges while one is pending are dropped.
- BURST:
  - Strobes are spaced as in RUN.
  - Each strobe decrements the remaining count.
  - The strobe that takes the remaining count to 0 also asserts `done` in the same cycle, and the FSM goes to IDLE.
- IDLE: `cpu_ce`=0. Synchronizer keeps running; edges are ignored.
- `hold`=1: counter frozen, `cpu_ce`=0, state retained.
- `ce_count` increments on every cycle with `cpu_ce`=1; 0xFFFF→0x0000 for CNT_W=16.
- Simultaneous events:
  - `cfg_load` beats a step edge or a counter terminal count in the same cycle; no strobe is emitted that cycle.
  - `cfg_load` beats `hold`; the load is still taken.

## Timing
- Reset (`reset_n`=0), immediate and asynchronous:
  - FSM=IDLE.
  - `cpu_ce`=0, `busy`=0, `done`=0, `ce_count`=0.
  - Counters and synchronizer flops = 0.
  - Latched mode=STOP, div=0, burst_len=0.
- Reset during RUN or BURST aborts the operation; no `done` is generated.
- RUN/BURST: with `cfg_load` high at edge k, the first `cpu_ce` is high during cycle k+1+div (no hold), then every div+1 cycles.
- STEP: `step_req` first sampled high at edge k (setup met) gives `cpu_ce` high during cycle k+3, exactly one cycle wide.
- `busy` rises the cycle after `cfg_load` and falls the cycle after the final burst strobe, i.e. together with the IDLE transition.
- `step_req` minimum pulse width and minimum low time: 3 clk cycles each for a guaranteed detect.

## Test plan
- Reset mid-RUN (div=3): assert `reset_n`=0 asynchronously → all outputs 0 within the same cycle; after release the block stays IDLE with no `cpu_ce`.
- RUN with div=3, then div=0: `cpu_ce` strobes exactly every 4 cycles, first at load+4; then every cycle; `ce_count`=100 after 100 strobes.
- BURST with burst_len=5, div=1: exactly 5 strobes, 2 cycles apart; `done` coincides with the 5th strobe; `busy` falls the next cycle. burst_len=0 → `done` one cycle after load, no strobe.
- STEP: three `step_req` pulses, each 5 cycles wide → exactly 3 strobes, each at edge+3. A pulse during `hold`=1 → strobe appears on the first cycle with `hold`=0.
- `hold` in RUN (div=7): assert `hold` at counter=5 for 10 cycles → no strobe during hold; next strobe 3 cycles after release.
- `cfg_load` coincident with terminal count and a step edge: no strobe that cycle, counter restarts from 0. Separately, force `ce_count`=0xFFFF → next strobe wraps it to 0x0000.
